amo_sequencer: RTL and testbench
================================

Name: amo_sequencer

Overview:
- Multi-cycle controller for the A-extension in the RV32IMA core; sits beside the MEM stage.
- Sequences LR.W, SC.W and AMO*.W read-modify-write transactions to data memory over a req/ready handshake.
- Holds the LR reservation and stalls the pipeline until the result is ready for writeback.

Parameters:
DATA_WIDTH, 32, data word width
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start_i  in  1  valid atomic instruction in MEM stage
funct5_i  in  5  instr[31:27] atomic operation
addr_i  in  ADDR_WIDTH  effective address (rs1)
rs2_data_i  in  DATA_WIDTH  operand / SC store data
mem_rdata_i  in  DATA_WIDTH  memory read data, valid when mem_ready_i=1 on a read
mem_ready_i  in  1  memory accepts/completes the current request
snoop_we_i  in  1  other-master or core store this cycle
snoop_addr_i  in  ADDR_WIDTH  address of that store
mem_req_o  out  1  memory request
mem_we_o  out  1  1=write, 0=read
mem_addr_o  out  ADDR_WIDTH  word-aligned request address
mem_wdata_o  out  DATA_WIDTH  write data
stall_o  out  1  hold pipeline
done_o  out  1  one-cycle pulse: result_o valid for rd writeback
result_o  out  DATA_WIDTH  rd value
illegal_o  out  1  pulse with done_o: unsupported funct5
misaligned_o  out  1  pulse with done_o: addr_i[1:0]!=0

Behaviour:
- Reset: state IDLE, reservation invalid; all outputs 0. Reset mid-transaction aborts immediately: mem_req_o drops asynchronously, no write is issued.
- FSM states: IDLE, READ, WRITE, DONE. Inputs are captured into internal registers on acceptance.
- IDLE, start_i=1:
  - If misaligned or illegal funct5 -> DONE with the matching flag; no memory access.
  - LR/AMO -> READ.
  - SC with reservation valid and word address (addr[31:2]) match -> WRITE; otherwise -> DONE with result 1.
- READ: mem_req_o=1, mem_we_o=0.
  - On mem_ready_i, LR goes to DONE, result=rdata, and the reservation is set.
  - On mem_ready_i, AMO goes to WRITE, old=rdata.
- WRITE: mem_req_o=1, mem_we_o=1.
  - AMO: wdata = op(old, rs2). SC: wdata = rs2.
  - On mem_ready_i -> DONE. Result is old for AMO, 0 for SC.
- DONE: done_o=1 for exactly one cycle, then -> IDLE. start_i is ignored in DONE; the pipeline presents the next instruction only after the stall is released.
- Memory handshake: addr, we and wdata are stable while mem_req_o=1 and mem_ready_i=0. mem_req_o never asserts outside READ/WRITE.
- stall_o = (IDLE & start_i) | READ | WRITE. It is 0 in DONE.
- Minimum latency with mem_ready_i tied high:
  - LR: 3 cycles, start to done_o.
  - AMO: 4 cycles.
  - Failed SC: 2 cycles.
- AMO ops, by funct5:
  - 00001 SWAP (rs2), 00000 ADD (mod 2^32), 00100 XOR, 01100 AND, 01000 OR.
  - 10000 MIN and 10100 MAX are signed compares.
  - 11000 MINU and 11100 MAXU are unsigned compares.
  - 00010 LR, 00011 SC.
  - Any other encoding is illegal.
- Reservation:
  - Cleared by any SC, pass or fail, on leaving DONE.
  - Cleared by snoop_we_i with a word match.
  - Cleared by a completed AMO write to the reserved word.
- Simultaneous events: if a snoop matches in the same cycle an LR completes READ to that word, the clear wins and the reservation ends invalid. A snoop to a different word has no effect.

Decomposition:
- Package amo_pkg:
  - funct5 constants / amo_op_t enum
  - state_t enum {IDLE, READ, WRITE, DONE}
  - WORD_LSB=2
- Sub-module amo_alu: combinational op(old, rs2, funct5) -> new value.
- The FSM and reservation register live in amo_sequencer.

Test Plan:
- LR at 0x100 (mem=0x5), then SC 0x100 rs2=0x9, ready tied high -> LR result 0x5 at done; SC writes 0x9 to 0x100, result 0.
- LR 0x100, snoop_we_i at 0x100, then SC 0x100 -> SC result 1, no mem write, done 2 cycles after start.
- AMOADD 0x200 (mem=0xFFFFFFFF), rs2=0x2 -> read then write 0x00000001; result 0xFFFFFFFF; stall_o high 3 cycles.
- AMOMIN vs AMOMINU with old=0x80000000, rs2=0x1 -> writes 0x80000000 for AMOMIN, 0x00000001 for AMOMINU.
- AMOSWAP with mem_ready_i low 3 cycles in both READ and WRITE -> mem_addr/we/wdata stable throughout; done_o single pulse.
- Reset asserted during WRITE -> mem_req_o drops the same cycle, state IDLE, reservation invalid; funct5=00101 -> illegal_o with done_o, no mem_req_o.

Source files
------------

// File: rtl/amo_pkg.sv
// Shared definitions for the atomic (A-extension) sequencer: operation
// encodings, FSM states and the word-address boundary.
package amo_pkg;

  // Byte-offset bits below the word address.
  localparam int WORD_LSB = 2;

  // instr[31:27] encodings of the supported atomic operations.
  typedef enum logic [4:0] {
    AMO_ADD  = 5'b00000,
    AMO_SWAP = 5'b00001,
    AMO_LR   = 5'b00010,
    AMO_SC   = 5'b00011,
    AMO_XOR  = 5'b00100,
    AMO_OR   = 5'b01000,
    AMO_AND  = 5'b01100,
    AMO_MIN  = 5'b10000,
    AMO_MAX  = 5'b10100,
    AMO_MINU = 5'b11000,
    AMO_MAXU = 5'b11100
  } amo_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // True for every funct5 the sequencer knows how to execute.
  function automatic logic funct5_legal(input logic [4:0] f);
    logic ok;
    case (f)
      AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
      AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: ok = 1'b1;
      default:                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational read-modify-write operator: computes the value an AMO
// stores back from the old memory word and rs2.
module amo_alu
  import amo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [4:0]            funct5,
  input  logic [DATA_WIDTH-1:0] old_val,
  input  logic [DATA_WIDTH-1:0] rs2_val,
  output logic [DATA_WIDTH-1:0] new_val
);

  logic lt_signed;
  logic lt_unsigned;

  assign lt_signed   = $signed(old_val) < $signed(rs2_val);
  assign lt_unsigned = old_val < rs2_val;

  // Select the stored value; LR/SC and illegal codes never reach a write
  // through this path, so they simply pass the old word.
  always_comb begin
    new_val = old_val;
    case (funct5)
      AMO_SWAP: new_val = rs2_val;
      AMO_ADD:  new_val = old_val + rs2_val;
      AMO_XOR:  new_val = old_val ^ rs2_val;
      AMO_AND:  new_val = old_val & rs2_val;
      AMO_OR:   new_val = old_val | rs2_val;
      AMO_MIN:  new_val = lt_signed   ? old_val : rs2_val;
      AMO_MAX:  new_val = lt_signed   ? rs2_val : old_val;
      AMO_MINU: new_val = lt_unsigned ? old_val : rs2_val;
      AMO_MAXU: new_val = lt_unsigned ? rs2_val : old_val;
      default:  new_val = old_val;
    endcase
  end

endmodule

// File: rtl/amo_sequencer.sv
// Multi-cycle sequencer for LR.W / SC.W / AMO*.W beside the MEM stage.
// Issues the read and/or write to data memory, keeps the LR reservation
// and stalls the pipeline until the rd result is ready.
//
// Memory handshake: mem_req_o is the request valid, mem_ready_i the
// accept/complete. A request completes in a cycle where both are high.
// While mem_req_o=1 and mem_ready_i=0, mem_addr_o, mem_we_o and
// mem_wdata_o hold their values (all are driven from registers captured
// before the request starts). mem_req_o is high only in READ and WRITE.
module amo_sequencer
  import amo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [4:0]            funct5_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ready_i,
  input  logic                  snoop_we_i,
  input  logic [ADDR_WIDTH-1:0] snoop_addr_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  illegal_o,
  output logic                  misaligned_o,
  output logic [1:0]            dbg_state_o,
  output logic                  dbg_resv_valid_o
);

  localparam int WW = ADDR_WIDTH - WORD_LSB;

  state_t                state_q, state_d;
  logic [4:0]            op_q;
  logic [WW-1:0]         addr_word_q;
  logic [DATA_WIDTH-1:0] rs2_q;
  logic [DATA_WIDTH-1:0] old_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  illegal_q;
  logic                  misaligned_q;
  logic                  resv_valid_q;
  logic [WW-1:0]         resv_word_q;

  logic [WW-1:0]         in_word;
  logic [WW-1:0]         snoop_word;
  logic                  in_misaligned;
  logic                  in_illegal;
  logic                  in_reject;
  logic                  in_is_sc;
  logic                  sc_hit;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  lr_complete;
  logic                  snoop_hit;
  logic                  amo_write_hit;
  logic                  sc_retire;
  logic                  unused_bits;

  assign in_word       = addr_i[ADDR_WIDTH-1:WORD_LSB];
  assign snoop_word    = snoop_addr_i[ADDR_WIDTH-1:WORD_LSB];
  assign in_misaligned = addr_i[WORD_LSB-1:0] != '0;
  assign in_illegal    = !funct5_legal(funct5_i);
  assign in_reject     = in_misaligned || in_illegal;
  assign in_is_sc      = funct5_i == AMO_SC;
  // A store snooped in the same cycle as the SC start already kills the
  // reservation, so it must not let the SC succeed on the stale flag.
  assign sc_hit        = resv_valid_q && (resv_word_q == in_word) &&
                         !(snoop_we_i && (snoop_word == in_word));
  assign unused_bits   = ^snoop_addr_i[WORD_LSB-1:0];

  amo_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .funct5  (op_q),
    .old_val (old_q),
    .rs2_val (rs2_q),
    .new_val (alu_out)
  );

  // State register; an asynchronous reset drops any request immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake/pipeline outputs.
  always_comb begin
    state_d   = state_q;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          stall_o = 1'b1;
          if (in_reject)     state_d = DONE;
          else if (in_is_sc) state_d = sc_hit ? WRITE : DONE;
          else               state_d = READ;
        end
      end
      READ: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        if (mem_ready_i) state_d = (op_q == AMO_LR) ? DONE : WRITE;
      end
      WRITE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        stall_o   = 1'b1;
        if (mem_ready_i) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the instruction on acceptance and collect read data / result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q         <= '0;
      addr_word_q  <= '0;
      rs2_q        <= '0;
      old_q        <= '0;
      result_q     <= '0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q         <= funct5_i;
            addr_word_q  <= in_word;
            rs2_q        <= rs2_data_i;
            illegal_q    <= in_illegal;
            misaligned_q <= in_misaligned;
            // A failed SC reports 1; rejected instructions report 0.
            if (!in_reject && in_is_sc && !sc_hit)
              result_q <= {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            else
              result_q <= '0;
          end
        end
        READ: begin
          if (mem_ready_i) begin
            old_q <= mem_rdata_i;
            if (op_q == AMO_LR) result_q <= mem_rdata_i;
          end
        end
        WRITE: begin
          if (mem_ready_i) result_q <= (op_q == AMO_SC) ? '0 : old_q;
        end
        default: ;
      endcase
    end
  end

  assign lr_complete   = (state_q == READ) && mem_ready_i && (op_q == AMO_LR);
  assign snoop_hit     = snoop_we_i && (snoop_word == resv_word_q);
  assign amo_write_hit = (state_q == WRITE) && mem_ready_i && (op_q != AMO_SC) &&
                         (addr_word_q == resv_word_q);
  assign sc_retire     = (state_q == DONE) && (op_q == AMO_SC);

  // Reservation: set by a completing LR unless a snoop hits that very word
  // in the same cycle; cleared by matching snoops, AMO writes and any SC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resv_valid_q <= 1'b0;
      resv_word_q  <= '0;
    end else if (lr_complete) begin
      resv_word_q  <= addr_word_q;
      resv_valid_q <= !(snoop_we_i && (snoop_word == addr_word_q));
    end else if (snoop_hit || amo_write_hit || sc_retire) begin
      resv_valid_q <= 1'b0;
    end
  end

  assign mem_addr_o       = {addr_word_q, {WORD_LSB{1'b0}}};
  assign mem_wdata_o      = (state_q != WRITE) ? '0 :
                            (op_q == AMO_SC)   ? rs2_q : alu_out;
  assign result_o         = (state_q == DONE) ? result_q : '0;
  assign illegal_o        = (state_q == DONE) && illegal_q;
  assign misaligned_o     = (state_q == DONE) && misaligned_q;
  assign dbg_state_o      = state_q;
  assign dbg_resv_valid_o = resv_valid_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// Directed bench for amo_sequencer: LR/SC pairing, snoop clearing,
// AMO arithmetic, back-pressure stability, reset abort and rejects.
module tb_amo_sequencer;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [4:0]  funct5_i;
  logic [31:0] addr_i;
  logic [31:0] rs2_data_i;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;
  logic        snoop_we_i;
  logic [31:0] snoop_addr_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        illegal_o;
  logic        misaligned_o;
  logic [1:0]  dbg_state_o;
  logic        dbg_resv_valid_o;

  int n_checks;
  int n_fail;

  // Observations from the last run_txn call.
  int          r_lat;
  int          r_stall;
  int          r_nreq;
  int          r_nwr;
  logic        r_done;
  logic [31:0] r_wdata;
  logic [31:0] r_waddr;
  logic [31:0] r_res;
  logic        r_ill;
  logic        r_mis;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  amo_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .funct5_i         (funct5_i),
    .addr_i           (addr_i),
    .rs2_data_i       (rs2_data_i),
    .mem_rdata_i      (mem_rdata_i),
    .mem_ready_i      (mem_ready_i),
    .snoop_we_i       (snoop_we_i),
    .snoop_addr_i     (snoop_addr_i),
    .mem_req_o        (mem_req_o),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .stall_o          (stall_o),
    .done_o           (done_o),
    .result_o         (result_o),
    .illegal_o        (illegal_o),
    .misaligned_o     (misaligned_o),
    .dbg_state_o      (dbg_state_o),
    .dbg_resv_valid_o (dbg_resv_valid_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: issue one instruction at the current negedge with memory
  // ready tied high, record what happens until done_o, and return at the
  // negedge after the DONE cycle.
  task automatic run_txn(input logic [4:0] f, input logic [31:0] a,
                         input logic [31:0] rs2, input logic [31:0] rdata);
    r_lat = 0; r_stall = 0; r_nreq = 0; r_nwr = 0; r_done = 1'b0;
    r_wdata = '0; r_waddr = '0; r_res = '0; r_ill = 1'b0; r_mis = 1'b0;
    start_i = 1'b1; funct5_i = f; addr_i = a; rs2_data_i = rs2;
    mem_rdata_i = rdata; mem_ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      r_lat++;
      if (stall_o) r_stall++;
      if (mem_req_o) r_nreq++;
      if (mem_req_o && mem_we_o && mem_ready_i) begin
        r_nwr++; r_wdata = mem_wdata_o; r_waddr = mem_addr_o;
      end
      if (done_o) begin
        r_done = 1'b1; r_res = result_o; r_ill = illegal_o; r_mis = misaligned_o;
        break;
      end
      @(negedge clk);
      start_i = 1'b0;
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_req_o, mem_we_o, stall_o, done_o, illegal_o, misaligned_o} !== 6'b0 ||
        mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || result_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h res=%h expected all 0",
                         mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, result_o);
    end
    n_checks++;
    if (dbg_state_o !== 2'd0 || dbg_resv_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: state=%0d resv=%b expected 0/0", dbg_state_o, dbg_resv_valid_o);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lr_sc();
    run_txn(F_LR, 32'h100, 32'h0, 32'h5);
    n_checks++;
    if (r_done !== 1'b1 || r_lat != 3 || r_res !== 32'h5) begin
      n_fail++; $display("FAIL lr_basic: done=%b lat=%0d res=%h expected 1/3/00000005", r_done, r_lat, r_res);
    end
    n_checks++;
    if (r_nwr != 0 || dbg_resv_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL lr_resv: writes=%0d resv=%b expected 0/1", r_nwr, dbg_resv_valid_o);
    end
    run_txn(F_SC, 32'h100, 32'h9, 32'h0);
    n_checks++;
    if (r_done !== 1'b1 || r_lat != 3 || r_res !== 32'h0) begin
      n_fail++; $display("FAIL sc_pass: done=%b lat=%0d res=%h expected 1/3/00000000", r_done, r_lat, r_res);
    end
    n_checks++;
    if (r_nwr != 1 || r_waddr !== 32'h100 || r_wdata !== 32'h9) begin
      n_fail++; $display("FAIL sc_write: writes=%0d addr=%h data=%h expected 1/00000100/00000009",
                         r_nwr, r_waddr, r_wdata);
    end
    n_checks++;
    if (dbg_resv_valid_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL sc_clears_resv: resv=%b done=%b expected 0/0", dbg_resv_valid_o, done_o);
    end
  endtask

  task automatic test_snoop();
    // Snoop to another word leaves the reservation alone.
    run_txn(F_LR, 32'h100, 32'h0, 32'h5);
    snoop_we_i = 1'b1; snoop_addr_i = 32'h204;
    @(negedge clk);
    snoop_we_i = 1'b0;
    n_checks++;
    if (dbg_resv_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL snoop_other_word: resv=%b expected 1", dbg_resv_valid_o);
    end
    // Snoop to the reserved word (different byte) kills it; SC then fails.
    snoop_we_i = 1'b1; snoop_addr_i = 32'h102;
    @(negedge clk);
    snoop_we_i = 1'b0;
    n_checks++;
    if (dbg_resv_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL snoop_match: resv=%b expected 0", dbg_resv_valid_o);
    end
    run_txn(F_SC, 32'h100, 32'h9, 32'h0);
    n_checks++;
    if (r_done !== 1'b1 || r_lat != 2 || r_res !== 32'h1 || r_nreq != 0) begin
      n_fail++; $display("FAIL sc_fail: done=%b lat=%0d res=%h req_cycles=%0d expected 1/2/00000001/0",
                         r_done, r_lat, r_res, r_nreq);
    end
    // Snoop hitting the word in the cycle the LR completes: clear wins.
    snoop_we_i = 1'b1; snoop_addr_i = 32'h140;
    run_txn(F_LR, 32'h140, 32'h0, 32'h77);
    snoop_we_i = 1'b0;
    n_checks++;
    if (r_res !== 32'h77 || dbg_resv_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL snoop_vs_lr: res=%h resv=%b expected 00000077/0", r_res, dbg_resv_valid_o);
    end
  endtask

  task automatic test_amo_add();
    run_txn(F_ADD, 32'h200, 32'h2, 32'hFFFF_FFFF);
    n_checks++;
    if (r_done !== 1'b1 || r_lat != 4 || r_stall != 3) begin
      n_fail++; $display("FAIL amoadd_timing: done=%b lat=%0d stall=%0d expected 1/4/3", r_done, r_lat, r_stall);
    end
    n_checks++;
    if (r_nwr != 1 || r_waddr !== 32'h200 || r_wdata !== 32'h1 || r_res !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL amoadd_data: writes=%0d addr=%h wdata=%h res=%h expected 1/00000200/00000001/ffffffff",
                         r_nwr, r_waddr, r_wdata, r_res);
    end
    // An AMO write to the reserved word clears the reservation.
    run_txn(F_LR, 32'h300, 32'h0, 32'h3);
    run_txn(F_OR, 32'h300, 32'h4, 32'h3);
    n_checks++;
    if (r_wdata !== 32'h7 || dbg_resv_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL amo_clears_resv: wdata=%h resv=%b expected 00000007/0", r_wdata, dbg_resv_valid_o);
    end
  endtask

  task automatic test_alu_ops();
    logic [4:0]  ops   [10] = '{F_MIN, F_MINU, F_MAX, F_MAXU, F_XOR, F_AND, F_OR, F_SWAP, F_XOR, F_ADD};
    logic [31:0] olds  [10] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234,
                                32'h0000_0000, 32'h7FFF_FFFF};
    logic [31:0] rs2s  [10] = '{32'h1, 32'h1, 32'h1, 32'h1,
                                32'h0FF0_4321, 32'h0FF0_4321, 32'h0FF0_4321, 32'h0FF0_4321,
                                32'hA5A5_A5A5, 32'h1};
    logic [31:0] exps  [10] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000,
                                32'hFF00_5115, 32'h00F0_0220, 32'hFFF0_5335, 32'h0FF0_4321,
                                32'hA5A5_A5A5, 32'h8000_0000};
    for (int i = 0; i < 10; i++) begin
      run_txn(ops[i], 32'h400 + 32'(i * 4), rs2s[i], olds[i]);
      n_checks++;
      if (r_nwr != 1 || r_wdata !== exps[i] || r_res !== olds[i]) begin
        n_fail++; $display("FAIL alu_op%0d funct5=%b: writes=%0d wdata=%h res=%h expected 1/%h/%h",
                           i, ops[i], r_nwr, r_wdata, r_res, exps[i], olds[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int pulses;
    logic stable;
    pulses = 0; stable = 1'b1;
    start_i = 1'b1; funct5_i = F_SWAP; addr_i = 32'h504; rs2_data_i = 32'hCAFE;
    mem_ready_i = 1'b0; mem_rdata_i = 32'h1111;
    @(negedge clk);
    start_i = 1'b0; addr_i = 32'hDEAD_0000; rs2_data_i = 32'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (!(mem_req_o && !mem_we_o && mem_addr_o == 32'h504 && stall_o)) stable = 1'b0;
      if (done_o) pulses++;
      @(negedge clk);
    end
    mem_ready_i = 1'b1;
    @(negedge clk);
    mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (!(mem_req_o && mem_we_o && mem_addr_o == 32'h504 && mem_wdata_o == 32'hCAFE)) stable = 1'b0;
      if (done_o) pulses++;
      @(negedge clk);
    end
    mem_ready_i = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++; $display("FAIL swap_stable: stable=%b expected 1", stable);
    end
    n_checks++;
    if (done_o !== 1'b1 || result_o !== 32'h1111 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL swap_done: done=%b res=%h stall=%b expected 1/00001111/0", done_o, result_o, stall_o);
    end
    if (done_o) pulses++;
    @(negedge clk);
    if (done_o) pulses++;
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL swap_pulse: pulses=%0d expected 1", pulses);
    end
  endtask

  task automatic test_reset_abort();
    run_txn(F_LR, 32'h600, 32'h0, 32'h6);
    n_checks++;
    if (dbg_resv_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL abort_setup: resv=%b expected 1", dbg_resv_valid_o);
    end
    start_i = 1'b1; funct5_i = F_ADD; addr_i = 32'h500; rs2_data_i = 32'h1;
    mem_rdata_i = 32'h7; mem_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    mem_ready_i = 1'b0;
    #1;
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_wdata_o !== 32'h8) begin
      n_fail++; $display("FAIL abort_in_write: req=%b we=%b wdata=%h expected 1/1/00000008", mem_req_o, mem_we_o, mem_wdata_o);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (mem_req_o !== 1'b0 || dbg_state_o !== 2'd0 || dbg_resv_valid_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_async: req=%b state=%0d resv=%b done=%b expected 0/0/0/0",
                         mem_req_o, dbg_state_o, dbg_resv_valid_o, done_o);
    end
    @(negedge clk);
    reset = 1'b0; mem_ready_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1'b0 || dbg_state_o !== 2'd0) begin
      n_fail++; $display("FAIL abort_after: req=%b state=%0d expected 0/0", mem_req_o, dbg_state_o);
    end
  endtask

  task automatic test_reject();
    run_txn(5'b00101, 32'h700, 32'h1, 32'h0);
    n_checks++;
    if (r_done !== 1'b1 || r_ill !== 1'b1 || r_mis !== 1'b0 || r_nreq != 0 || r_lat != 2) begin
      n_fail++; $display("FAIL illegal: done=%b ill=%b mis=%b req_cycles=%0d lat=%0d expected 1/1/0/0/2",
                         r_done, r_ill, r_mis, r_nreq, r_lat);
    end
    run_txn(F_LR, 32'h702, 32'h0, 32'h0);
    n_checks++;
    if (r_done !== 1'b1 || r_mis !== 1'b1 || r_ill !== 1'b0 || r_nreq != 0 || dbg_resv_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL misaligned: done=%b mis=%b ill=%b req_cycles=%0d resv=%b expected 1/1/0/0/0",
                         r_done, r_mis, r_ill, r_nreq, dbg_resv_valid_o);
    end
    n_checks++;
    if (illegal_o !== 1'b0 || misaligned_o !== 1'b0) begin
      n_fail++; $display("FAIL flags_idle: ill=%b mis=%b expected 0/0", illegal_o, misaligned_o);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; start_i = 1'b0; funct5_i = '0; addr_i = '0; rs2_data_i = '0;
    mem_rdata_i = '0; mem_ready_i = 1'b0; snoop_we_i = 1'b0; snoop_addr_i = '0;
    test_reset();
    test_lr_sc();
    test_snoop();
    test_amo_add();
    test_alu_ops();
    test_backpressure();
    test_reset_abort();
    test_reject();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
